object_counter: RTL and testbench
=================================

Name: object_counter

Overview:
- Downstream consumer of top_ultrasonic: takes its object_detected_o level and turns it into a debounced presence flag and an object count.
- Drives the Smarcount display and reporting logic.
- Each object pass counts exactly once. A pass is one confirmed absent→present→absent episode. Glitches and single-measurement dropouts from the 60 ms ultrasonic cycle are filtered out.

Parameters:
- COUNT_W, 16, width of count_o.
- ON_CYCLES, 1_000_000, consecutive high cycles needed to confirm presence (20 ms at 50 MHz); must be ≥ 1.
- OFF_CYCLES, 7_500_000, consecutive low cycles needed to confirm absence (150 ms, more than 2 measurement periods); must be ≥ 1.
- COUNT_LIMIT, 9999, count ceiling; used only with OBJCNT_LIMIT_EN.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- object_detected_i  input  1  level from top_ultrasonic object_detected_o; synchronous to clk.
- count_clear_i  input  1  synchronous clear of count_o and overflow_o.
- count_o  output  COUNT_W  number of objects counted.
- count_pulse_o  output  1  one-cycle strobe, high in the same cycle count_o takes its new value.
- present_o  output  1  debounced presence; 1 in PRESENT and RELEASE.
- overflow_o  output  1  sticky; set when count_o wraps from all-ones to 0.
- limit_reached_o  output  1  see Optional Feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=IDLE, timer=0, det_q=0.
  - count_o=0, count_pulse_o=0, present_o=0, overflow_o=0, limit_reached_o=0.
  - Reset mid-episode discards all progress; no count is emitted.
- Input register: det_q <= object_detected_i every cycle. The FSM uses only det_q.
- Timer:
  - Width is $clog2(max(ON_CYCLES, OFF_CYCLES)+1).
  - Cleared on every state change.
  - Increments while det_q matches the target level of the current state.
- FSM:
  - IDLE: det_q=1 → CONFIRM, timer=1.
  - CONFIRM:
    - det_q=0 → IDLE.
    - det_q=1 with timer==ON_CYCLES-1 → PRESENT and increment.
    - Otherwise timer++.
    - If ON_CYCLES=1, IDLE goes straight to PRESENT on the first det_q=1 and increments.
  - PRESENT: det_q=0 → RELEASE, timer=1. det_q=1 → stay.
  - RELEASE:
    - det_q=1 → PRESENT, with no increment.
    - det_q=0 with timer==OFF_CYCLES-1 → IDLE.
    - Otherwise timer++.
    - If OFF_CYCLES=1, PRESENT goes straight to IDLE.
- Latency:
  - count_pulse_o rises ON_CYCLES+1 clocks after the first sampled high of object_detected_i.
  - present_o rises in the same cycle as count_pulse_o.
  - present_o falls OFF_CYCLES+1 clocks after the first sampled low.
- Increment:
  - count_o <= count_o+1, modulo 2^COUNT_W.
  - On wrap from all-ones to 0, overflow_o <= 1 (sticky).
  - count_pulse_o=1 for exactly one cycle per increment.
- count_clear_i:
  - Sets count_o=0 and overflow_o=0 the next cycle.
  - Has priority over a same-cycle increment: the increment is dropped and count_pulse_o stays 0.
  - Does not affect FSM, timer or present_o.
- count_o stays constant except on an increment or a clear.

Optional Feature:
- Macro: OBJCNT_LIMIT_EN.
- Defined:
  - When an increment would make count_o reach COUNT_LIMIT, count_o=COUNT_LIMIT and limit_reached_o=1.
  - Further confirmed objects do not change count_o and do not pulse count_pulse_o.
  - The FSM keeps running and present_o behaves normally.
  - count_clear_i clears limit_reached_o.
  - Wrap cannot occur, so overflow_o stays 0.
- Not defined:
  - limit_reached_o is tied to 0.
  - The count wraps as described in Behaviour.

Test Plan (bench params: COUNT_W=4, ON_CYCLES=4, OFF_CYCLES=6, COUNT_LIMIT=5):
- Reset: rst=0 with object_detected_i=1 → all outputs 0. Release at cycle 0 with input held high → count_pulse_o high at cycle 5, count_o=1, present_o=1.
- Glitch: input high 3 cycles then low → count_o stays 0, present_o stays 0, FSM returns to IDLE.
- Dropout: in PRESENT, input low 4 cycles then high → no new count, present_o stays 1. Then input low 10 cycles → present_o falls 7 cycles after the first low. A new 4-cycle high → count_o=2.
- Wrap: 16 full episodes → count_o goes 15→0 and overflow_o=1. count_clear_i=1 for one cycle → count_o=0, overflow_o=0.
- Clear collision: assert count_clear_i in the cycle the increment would occur → count_o=0, count_pulse_o=0, present_o=1.
- OBJCNT_LIMIT_EN defined: 7 episodes → count_o=5, limit_reached_o=1, only 5 pulses seen. count_clear_i → count_o=0, limit_reached_o=0.

Source files
------------

// File: rtl/object_counter.sv
// object_counter
//   Debounces the ultrasonic object_detected level into a presence flag and
//   counts each confirmed absent->present->absent pass exactly once.
//   Short highs (glitches) never reach PRESENT. Short lows (single
//   measurement dropouts) are absorbed in RELEASE and do not end the pass.
//
// Optional feature: define OBJCNT_LIMIT_EN to saturate the count at
//   COUNT_LIMIT and report it on limit_reached_o. Without the macro the count
//   wraps modulo 2^COUNT_W and limit_reached_o is tied low.
//
// Ports:
//   clk               system clock
//   rst               asynchronous reset, active low
//   object_detected_i raw presence level, synchronous to clk
//   count_clear_i     synchronous clear of count_o / overflow_o / limit flag
//   count_o           number of counted objects
//   count_pulse_o     one-cycle strobe, same cycle count_o changes on increment
//   present_o         debounced presence (PRESENT or RELEASE)
//   overflow_o        sticky, set when count_o wraps all-ones -> 0
//   limit_reached_o   count saturated at COUNT_LIMIT (OBJCNT_LIMIT_EN only)
module object_counter #(
  parameter int COUNT_W     = 16,
  parameter int ON_CYCLES   = 1_000_000,
  parameter int OFF_CYCLES  = 7_500_000,
  parameter int COUNT_LIMIT = 9999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               object_detected_i,
  input  logic               count_clear_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               count_pulse_o,
  output logic               present_o,
  output logic               overflow_o,
  output logic               limit_reached_o
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESENT, RELEASE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          det_q;
  logic          inc;

  // Input register; the FSM only ever looks at det_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) det_q <= 1'b0;
    else      det_q <= object_detected_i;
  end

  // Presence is confirmed on this edge: the count update must land on the
  // same edge the FSM enters PRESENT so that pulse and present rise together.
  always_comb begin
    inc = 1'b0;
    if (det_q) begin
      if (state == IDLE && ON_CYCLES == 1)       inc = 1'b1;
      if (state == CONFIRM && timer == ON_LAST)  inc = 1'b1;
    end
  end

  // Debounce FSM. The timer counts consecutive samples at the level the
  // current state is waiting for; entering CONFIRM/RELEASE already counts
  // the first such sample, hence timer=1 there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      present_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (det_q) begin
            if (ON_CYCLES == 1) begin
              state     <= PRESENT;
              timer     <= '0;
              present_o <= 1'b1;
            end else begin
              state <= CONFIRM;
              timer <= TW'(1);
            end
          end
        end
        CONFIRM: begin
          if (!det_q) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == ON_LAST) begin
            state     <= PRESENT;
            timer     <= '0;
            present_o <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PRESENT: begin
          if (!det_q) begin
            if (OFF_CYCLES == 1) begin
              state     <= IDLE;
              timer     <= '0;
              present_o <= 1'b0;
            end else begin
              state <= RELEASE;
              timer <= TW'(1);
            end
          end
        end
        RELEASE: begin
          // A high during RELEASE is a dropout recovery: same object, no count.
          if (det_q) begin
            state <= PRESENT;
            timer <= '0;
          end else if (timer == OFF_LAST) begin
            state     <= IDLE;
            timer     <= '0;
            present_o <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          timer     <= '0;
          present_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef OBJCNT_LIMIT_EN
  localparam logic [COUNT_W-1:0] LIMIT_V = COUNT_W'(COUNT_LIMIT);

  // Saturating counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_o         <= '0;
      count_pulse_o   <= 1'b0;
      overflow_o      <= 1'b0;
      limit_reached_o <= 1'b0;
    end else begin
      count_pulse_o <= 1'b0;
      if (count_clear_i) begin
        count_o         <= '0;
        overflow_o      <= 1'b0;
        limit_reached_o <= 1'b0;
      end else if (inc && count_o < LIMIT_V) begin
        count_o       <= count_o + 1'b1;
        count_pulse_o <= 1'b1;
        if (count_o + 1'b1 == LIMIT_V) limit_reached_o <= 1'b1;
      end
    end
  end
`else
  assign limit_reached_o = 1'b0;

  // Wrapping counter with sticky overflow; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_o       <= '0;
      count_pulse_o <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      count_pulse_o <= 1'b0;
      if (count_clear_i) begin
        count_o    <= '0;
        overflow_o <= 1'b0;
      end else if (inc) begin
        count_o       <= count_o + 1'b1;
        count_pulse_o <= 1'b1;
        if (&count_o) overflow_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_object_counter.sv
// tb_object_counter
//   Randomized + directed bench for object_counter (COUNT_W=4, ON=4, OFF=6,
//   LIMIT=5). The reference model describes presence as "ON consecutive high
//   samples confirm, OFF consecutive low samples release" using run-length
//   counters, and the count as plain integer arithmetic.
module tb_object_counter;

  localparam int CW    = 4;
  localparam int ON    = 4;
  localparam int OFF   = 6;
  localparam int LIMIT = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          det = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] count;
  logic          pulse, present, overflow, limit_r;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  object_counter #(.COUNT_W(CW), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .COUNT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .object_detected_i(det), .count_clear_i(clr),
    .count_o(count), .count_pulse_o(pulse), .present_o(present),
    .overflow_o(overflow), .limit_reached_o(limit_r)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_det, hi, lo, m_pres, m_cnt, m_pulse, m_ovf, m_lim;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_det = 0; hi = 0; lo = 0; m_pres = 0;
      m_cnt = 0; m_pulse = 0; m_ovf = 0; m_lim = 0;
    end else begin
      int inc;
      inc = 0;
      if (m_det != 0) begin hi = hi + 1; lo = 0; end
      else            begin lo = lo + 1; hi = 0; end
      if (m_pres == 0 && hi >= ON) begin m_pres = 1; inc = 1; end
      else if (m_pres != 0 && lo >= OFF) m_pres = 0;
      m_pulse = 0;
      if (clr) begin
        m_cnt = 0; m_ovf = 0; m_lim = 0;
      end else if (inc != 0) begin
`ifdef OBJCNT_LIMIT_EN
        if (m_cnt < LIMIT) begin
          m_cnt = m_cnt + 1; m_pulse = 1;
          if (m_cnt == LIMIT) m_lim = 1;
        end
`else
        m_cnt = (m_cnt + 1) % (1 << CW); m_pulse = 1;
        if (m_cnt == 0) m_ovf = 1;
`endif
      end
      m_det = int'(det);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    checks = checks + 1;
    if (int'(count) != m_cnt || int'(pulse) != m_pulse || int'(present) != m_pres ||
        int'(overflow) != m_ovf || int'(limit_r) != m_lim) begin
      failures = failures + 1;
      $display("FAIL model t=%0t got cnt=%0d pls=%0d pres=%0d ovf=%0d lim=%0d exp cnt=%0d pls=%0d pres=%0d ovf=%0d lim=%0d",
               $time, count, pulse, present, overflow, limit_r,
               m_cnt, m_pulse, m_pres, m_ovf, m_lim);
    end
    if (pulse) pulses = pulses + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic episode(input int hi_n, input int lo_n);
    det = 1'b1; cyc(hi_n);
    det = 1'b0; cyc(lo_n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, p0, lvl, len;

    // Reset held with input high: everything quiet.
    rst = 1'b0; det = 1'b1; clr = 1'b0;
    cyc(3);
    chk("reset_count", int'(count), 0);
    chk("reset_outs", int'({pulse, present, overflow, limit_r}), 0);

    // Release with input held high: pulse exactly at cycle 5.
    rst = 1'b1;
    cyc(4);
    chk("first_pulse_early", int'(pulse), 0);
    cyc(1);
    chk("first_pulse", int'(pulse), 1);
    chk("first_count", int'(count), 1);
    chk("first_present", int'(present), 1);
    cyc(1);
    chk("pulse_one_cycle", int'(pulse), 0);
    det = 1'b0; cyc(10);
    chk("first_release", int'(present), 0);

    // Glitch: 3 highs never confirm.
    episode(3, 10);
    chk("glitch_count", int'(count), 1);
    chk("glitch_present", int'(present), 0);

    // Dropout of 4 lows inside PRESENT is absorbed.
    det = 1'b1; cyc(6);
    chk("dropout_pre_count", int'(count), 2);
    det = 1'b0; cyc(4);
    det = 1'b1; cyc(3);
    chk("dropout_count", int'(count), 2);
    chk("dropout_present", int'(present), 1);
    det = 1'b0;
    n = 0;
    while (present && n < 30) begin cyc(1); n++; end
    chk("release_latency", n, OFF + 1);
    cyc(4);
    episode(6, 10);
    chk("after_dropout_count", int'(count), 3);

    // Clear, then 16 full episodes (wrap or saturate).
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clear_count", int'(count), 0);
    p0 = pulses;
    for (int i = 0; i < 15; i++) episode(5, 8);
`ifdef OBJCNT_LIMIT_EN
    chk("sat_count15", int'(count), LIMIT);
    chk("sat_limit", int'(limit_r), 1);
`else
    chk("pre_wrap_count", int'(count), 15);
    chk("pre_wrap_ovf", int'(overflow), 0);
`endif
    episode(5, 8);
`ifdef OBJCNT_LIMIT_EN
    chk("sat_count", int'(count), LIMIT);
    chk("sat_ovf", int'(overflow), 0);
    chk("sat_pulses", pulses - p0, LIMIT);
`else
    chk("wrap_count", int'(count), 0);
    chk("wrap_ovf", int'(overflow), 1);
    chk("wrap_pulses", pulses - p0, 16);
`endif
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("clear2_count", int'(count), 0);
    chk("clear2_flags", int'({overflow, limit_r}), 0);

    // Clear colliding with the increment edge.
    episode(5, 8);
    chk("coll_pre_count", int'(count), 1);
    det = 1'b1; cyc(4);
    clr = 1'b1; cyc(1); clr = 1'b0;
    chk("coll_count", int'(count), 0);
    chk("coll_pulse", int'(pulse), 0);
    chk("coll_present", int'(present), 1);
    det = 1'b0; cyc(10);

    // Random runs, occasional clears and mid-episode resets.
    for (int r = 0; r < 400; r++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 12);
      det = lvl[0];
      for (int k = 0; k < len; k++) begin
        clr = ($urandom_range(0, 39) == 0);
        rst = ($urandom_range(0, 499) != 0);
        cyc(1);
      end
    end
    rst = 1'b1; clr = 1'b0; det = 1'b0;
    cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
